cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single pipelined main-memory port between the I-cache fill FSM
//  and the D-cache fill FSM / write-through store path.
//  Grants one requester at a time and holds the grant for a full 8-word burst,
//  including the drain of outstanding responses. Stalls the losing fill FSM.
//  Routes mem_data_valid back to the granted requester only.
//  Sits between both cache controllers and the memory model.
// PARAMETERS
//  ADDR_W     16  memory address width
//  DATA_W     16  memory data width
//  BURST_LEN  8   read beats per fill; counters are 4-bit, legal range 1..15
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  i_miss        in   1       I-cache fill request, level, held until serviced
//  i_addr        in   ADDR_W  I-cache fill FSM beat address
//  d_miss        in   1       D-cache fill request, level
//  d_addr        in   ADDR_W  D-cache fill FSM beat address, or store address
//  d_wr          in   1       D-cache write-through store request, level
//  d_wdata       in   DATA_W  store data
//  mem_data_valid in  1       memory read response valid
//  mem_enable    out  1       memory access strobe
//  mem_wr        out  1       1 = write, 0 = read
//  mem_addr      out  ADDR_W  memory address
//  mem_wdata     out  DATA_W  memory write data
//  i_grant       out  1       I-cache owns the port
//  d_grant       out  1       D-cache owns the port (fill or store)
//  i_stall       out  1       i_miss & ~i_grant
//  d_stall       out  1       (d_miss | d_wr) & ~d_grant
//  i_data_valid  out  1       mem_data_valid & (state==I_FILL)
//  d_data_valid  out  1       mem_data_valid & (state==D_FILL)
//  d_wr_ack      out  1       one-cycle pulse: store issued
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, RR pointer = D; every output 0.
//  - FSM states: IDLE, I_FILL, D_FILL, D_WRITE (registered).
//  - IDLE selection priority, fixed: d_wr > d_miss > i_miss.
//    Decision at edge N; grant visible from cycle N+1.
//  - FILL: issue phase = BURST_LEN consecutive cycles.
//    In each: mem_enable=1, mem_wr=0, mem_addr = grantee's addr input.
//    issue_cnt increments per beat.
//  - Drain phase: mem_enable=0; ret_cnt increments on each mem_data_valid.
//    Valids arriving during issue phase also count.
//  - When ret_cnt reaches BURST_LEN: IDLE next edge, grant drops.
//    A new grant needs at least one IDLE cycle between bursts.
//  - D_WRITE: one cycle. mem_enable=1, mem_wr=1, mem_addr=d_addr,
//    mem_wdata=d_wdata, d_wr_ack=1. Then IDLE.
//  - mem_wdata = 0 when not in D_WRITE. mem_addr = 0 when mem_enable=0.
//  - mem_data_valid in IDLE/D_WRITE is ignored: no *_data_valid, no count.
//  - Requests arriving mid-burst wait; the ongoing burst is never preempted.
//  - Request dropped mid-burst: burst completes anyway. Responses still route.
//  - Async rst mid-burst: immediate return to IDLE, outputs 0, counters cleared.
//    Responses still in flight after reset are ignored.
// CONFIGURATION
//  CACHE_ARB_RR_EN defined:
//   - Round-robin between I and D fills. The last completed fill loses a tie.
//   - Stores keep absolute priority.
//   - A store still cannot take two consecutive grants while i_miss waits.
//  CACHE_ARB_RR_EN undefined: fixed priority as above. No RR pointer flop.
// TESTING
//  - Reset mid-burst: rst at beat 3 of D_FILL -> all outputs 0 same cycle.
//    Then i_miss alone -> i_grant=1 one cycle after rst falls.
//  - Lone i_miss, addr 0x0040..0x004E, valids 4 cycles after each beat:
//    8 beats with mem_enable=1, i_data_valid x8, busy=0 on the edge after the 8th.
//  - i_miss and d_miss together (RR off): D_FILL first, i_stall=1 throughout.
//    I_FILL begins 2 cycles after D's last valid.
//  - Same with CACHE_ARB_RR_EN and last fill = D: I_FILL wins first.
//    Second tie afterwards: D wins.
//  - d_wr asserted during I_FILL beat 2: waits. After drain, D_WRITE with
//    mem_wr=1, addr 0x1234, data 0xBEEF, d_wr_ack pulse. i_data_valid count = 8.
//  - Stray mem_data_valid in IDLE: no *_data_valid, next burst still counts 8.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one pipelined main-memory port between the I-cache fill FSM and the
// D-cache fill FSM / write-through store path. One requester owns the port at
// a time. A fill owns it for a full burst: BURST_LEN issue cycles followed by
// the drain of every outstanding read response. A store owns it for a single
// cycle. The requester that loses is stalled. Read responses are routed only
// to the requester that currently owns the port.
//
// Optional feature (compile-time macro CACHE_ARB_RR_EN):
//   defined   - I and D fills alternate on a tie, and the fill that completed
//               last loses. Stores keep absolute priority, except that a
//               store cannot win two grants in a row while i_miss waits.
//   undefined - fixed priority d_wr > d_miss > i_miss, with no pointer state.
//
// Handshake: each request (i_miss, d_miss, d_wr) is a level. The requester
// holds it until it has been serviced. The matching *_grant output is the
// acceptance. For a store, the d_wr_ack pulse marks the single cycle in which
// the write is presented to memory.
//
// Ports
//   clk, rst        clock (rising edge); asynchronous active-high reset
//   i_miss, i_addr  I-cache fill request and current beat address
//   d_miss, d_addr  D-cache fill request; beat address or store address
//   d_wr, d_wdata   D-cache write-through store request and data
//   mem_data_valid  memory read response valid
//   mem_enable, mem_wr, mem_addr, mem_wdata   memory command port
//   i_grant, d_grant  current owner of the port
//   i_stall, d_stall  requester is waiting for the port
//   i_data_valid, d_data_valid  routed read responses
//   d_wr_ack        one-cycle pulse in the cycle a store is issued
//   busy            the arbiter is not idle
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8    // 1..15, the beat counters are 4 bits
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              mem_data_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_stall,
    output logic              d_stall,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              d_wr_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    localparam logic [3:0] BURST = 4'(BURST_LEN);

    state_t     state, state_nxt, sel_state;
    logic [3:0] issue_cnt, ret_cnt;
    logic [3:0] issue_cnt_nxt, ret_cnt_nxt;
    logic [3:0] issue_cnt_inc, ret_cnt_inc;
    logic       in_fill, issuing, ret_beat, fill_done;

    assign in_fill  = (state == I_FILL) || (state == D_FILL);
    assign issuing  = in_fill && (issue_cnt != BURST);
    // Responses are counted only while a fill owns the port. Responses that
    // arrive during the issue phase also count. The counter saturates so a
    // stray extra response cannot wrap it.
    assign ret_beat = in_fill && mem_data_valid && (ret_cnt != BURST);

    assign issue_cnt_inc = issue_cnt + {3'b000, issuing};
    assign ret_cnt_inc   = ret_cnt + {3'b000, ret_beat};
    // The burst ends on the edge that takes the last response.
    assign fill_done     = in_fill && (issue_cnt_inc == BURST) && (ret_cnt_inc == BURST);

`ifdef CACHE_ARB_RR_EN
    // last_fill_d: the fill that completed most recently was a D fill.
    //   This flag loses the next I/D tie.
    // last_store: the most recent grant went to a store.
    logic last_fill_d;
    logic last_store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_fill_d <= 1'b1;
            last_store  <= 1'b0;
        end else begin
            if (fill_done)
                last_fill_d <= (state == D_FILL);
            if (state == IDLE && state_nxt == D_WRITE)
                last_store <= 1'b1;
            else if (state == IDLE && (state_nxt == I_FILL || state_nxt == D_FILL))
                last_store <= 1'b0;
        end
    end

    always_comb begin
        sel_state = IDLE;
        if (d_wr && !(last_store && i_miss))
            sel_state = D_WRITE;
        else if (i_miss && d_miss)
            sel_state = last_fill_d ? I_FILL : D_FILL;
        else if (d_miss)
            sel_state = D_FILL;
        else if (i_miss)
            sel_state = I_FILL;
    end
`else
    always_comb begin
        sel_state = IDLE;
        if (d_wr)
            sel_state = D_WRITE;
        else if (d_miss)
            sel_state = D_FILL;
        else if (i_miss)
            sel_state = I_FILL;
    end
`endif

    // State and beat counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= 4'd0;
            ret_cnt   <= 4'd0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_cnt_nxt;
            ret_cnt   <= ret_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        issue_cnt_nxt = issue_cnt;
        ret_cnt_nxt   = ret_cnt;
        case (state)
            IDLE: begin
                // The grant is decided here and becomes visible in the next
                // cycle. This guarantees at least one idle cycle between
                // bursts.
                state_nxt = sel_state;
            end
            I_FILL, D_FILL: begin
                issue_cnt_nxt = issue_cnt_inc;
                ret_cnt_nxt   = ret_cnt_inc;
                if (fill_done) begin
                    state_nxt     = IDLE;
                    issue_cnt_nxt = 4'd0;
                    ret_cnt_nxt   = 4'd0;
                end
            end
            D_WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                issue_cnt_nxt = 4'd0;
                ret_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs: all are decoded from registered state, so an asynchronous reset
    // clears them in the same cycle.
    always_comb begin
        mem_enable = issuing || (state == D_WRITE);
        mem_wr     = (state == D_WRITE);
        mem_addr   = '0;
        if (mem_enable)
            mem_addr = (state == I_FILL) ? i_addr : d_addr;
        mem_wdata  = (state == D_WRITE) ? d_wdata : '0;
    end

    assign i_grant      = (state == I_FILL);
    assign d_grant      = (state == D_FILL) || (state == D_WRITE);
    // Stalls are masked during reset so every output reads 0 while rst is high.
    assign i_stall      = i_miss && !i_grant && !rst;
    assign d_stall      = (d_miss || d_wr) && !d_grant && !rst;
    assign i_data_valid = mem_data_valid && (state == I_FILL);
    assign d_data_valid = mem_data_valid && (state == D_FILL);
    assign d_wr_ack     = (state == D_WRITE);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Directed bench for cache_mem_arbiter. The memory model returns one read
// response four cycles after each issued read beat. The stepping task moves
// to the middle of the next cycle and plays the fill FSMs: it advances the
// granted requester's beat address by 2 after every issued beat, and it
// records issued addresses and routed responses.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 8;

`ifdef CACHE_ARB_RR_EN
  localparam bit TIE_FIRST_I = 1'b1;
`else
  localparam bit TIE_FIRST_I = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_miss = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              d_miss = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic              d_wr = 1'b0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              mem_data_valid = 1'b0;
  logic              mem_enable, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              i_grant, d_grant, i_stall, d_stall;
  logic              i_data_valid, d_data_valid, d_wr_ack, busy;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr),
    .d_wr(d_wr), .d_wdata(d_wdata),
    .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_stall(i_stall), .d_stall(d_stall),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .d_wr_ack(d_wr_ack), .busy(busy)
  );

  // ---------------- memory model ----------------
  // A read beat seen in cycle c gives a response in cycle c+4. stray injects
  // one unsolicited response.
  logic [7:0] pipe = '0;
  logic       stray = 1'b0;
  always @(negedge clk) begin
    if (rst) pipe = '0;
    else     pipe = {pipe[6:0], mem_enable & ~mem_wr};
    mem_data_valid = pipe[4] | stray;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int i_vcnt, d_vcnt, rd_beats, stall_gap;
  logic [ADDR_W-1:0] obs_q[$];
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    i_vcnt = 0; d_vcnt = 0; rd_beats = 0; stall_gap = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Move to the middle of the next cycle, sample outputs, and advance the
  // requester addresses.
  task automatic step();
    @(negedge clk);
    #2;
    if (i_data_valid) i_vcnt++;
    if (d_data_valid) d_vcnt++;
    if (i_miss && !i_grant && !i_stall) stall_gap++;
    if ((d_miss || d_wr) && !d_grant && !d_stall) stall_gap++;
    if (mem_enable && !mem_wr) begin
      rd_beats++;
      obs_q.push_back(mem_addr);
      if (i_grant) i_addr = i_addr + 16'd2;
      if (d_grant) d_addr = d_addr + 16'd2;
    end
  endtask

  // Run the owning fill to completion. The request is dropped in the cycle
  // that delivers the last response. Returns the cycle index of the last
  // response and the cycle index of the first idle cycle; with a fault these
  // stay at -1.
  task automatic finish_fill(input bit is_i, output int tgt, output int idle);
    int n;
    n = 0; tgt = -1; idle = -1;
    while (n < 200) begin
      step();
      n++;
      if (tgt < 0 && (is_i ? i_vcnt : d_vcnt) >= BURST_LEN) begin
        tgt = n;
        if (is_i) i_miss = 1'b0; else d_miss = 1'b0;
      end
      if (!busy) begin
        idle = n;
        break;
      end
    end
    if (idle < 0) begin
      i_miss = 1'b0; d_miss = 1'b0;
    end
  endtask

  int tgt, idle, budget;

  initial begin
    clear_counts();

    // ---- reset state: every output 0, even with requests pending ----
    i_miss = 1'b1; d_wr = 1'b1;
    step();
    check("rst_busy", busy, 0);
    check("rst_i_grant", i_grant, 0);
    check("rst_d_grant", d_grant, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_i_stall", i_stall, 0);
    check("rst_d_stall", d_stall, 0);
    check("rst_d_wr_ack", d_wr_ack, 0);
    i_miss = 1'b0; d_wr = 1'b0;
    step();
    rst = 1'b0;
    step();

    // ---- tie between I and D fills ----
    clear_counts();
    i_addr = 16'h0200; d_addr = 16'h0100;
    i_miss = 1'b1; d_miss = 1'b1;
    #1;
    check("tie_i_stall_req", i_stall, 1);
    check("tie_d_stall_req", d_stall, 1);
    step();
    check("tie_first_i_grant", i_grant, TIE_FIRST_I);
    check("tie_first_d_grant", d_grant, !TIE_FIRST_I);
    finish_fill(TIE_FIRST_I, tgt, idle);
    check("tie_first_done_lat", 32'(idle - tgt), 1);
    check("tie_first_cnt", TIE_FIRST_I ? i_vcnt : d_vcnt, BURST_LEN);
    check("tie_gap_i_grant", i_grant, 0);
    check("tie_gap_d_grant", d_grant, 0);
    step();
    check("tie_second_i_grant", i_grant, !TIE_FIRST_I);
    check("tie_second_d_grant", d_grant, TIE_FIRST_I);
    finish_fill(!TIE_FIRST_I, tgt, idle);
    check("tie_second_done_lat", 32'(idle - tgt), 1);
    check("tie_i_vcnt", i_vcnt, BURST_LEN);
    check("tie_d_vcnt", d_vcnt, BURST_LEN);
    check("tie_stall_gap", stall_gap, 0);
    step();

    // ---- lone i_miss, addresses 0x0040..0x004E ----
    clear_counts();
    i_addr = 16'h0040;
    i_miss = 1'b1;
    #1;
    check("lone_i_grant_early", i_grant, 0);
    step();
    check("lone_i_grant", i_grant, 1);
    check("lone_mem_enable", mem_enable, 1);
    check("lone_mem_wr", mem_wr, 0);
    finish_fill(1'b1, tgt, idle);
    check("lone_done_lat", 32'(idle - tgt), 1);
    check("lone_i_vcnt", i_vcnt, 8);
    check("lone_d_vcnt", d_vcnt, 0);
    check("lone_beats", rd_beats, 8);
    for (int k = 0; k < 8; k++) exp_q.push_back(16'h0040 + 16'(2 * k));
    check("lone_addr_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check("lone_addr", obs_q.pop_front(), exp_q.pop_front());
    step();

    // ---- store arriving during I_FILL beat 2 ----
    clear_counts();
    i_addr = 16'h0300;
    i_miss = 1'b1;
    step();
    step();
    check("st_beat2", rd_beats, 2);
    d_addr = 16'h1234; d_wdata = 16'hBEEF; d_wr = 1'b1;
    #1;
    check("st_d_stall", d_stall, 1);
    check("st_mem_wr_fill", mem_wr, 0);
    finish_fill(1'b1, tgt, idle);
    check("st_fill_done_lat", 32'(idle - tgt), 1);
    check("st_i_vcnt", i_vcnt, 8);
    check("st_idle_d_grant", d_grant, 0);
    check("st_idle_d_stall", d_stall, 1);
    step();
    check("st_mem_enable", mem_enable, 1);
    check("st_mem_wr", mem_wr, 1);
    check("st_mem_addr", mem_addr, 16'h1234);
    check("st_mem_wdata", mem_wdata, 16'hBEEF);
    check("st_d_wr_ack", d_wr_ack, 1);
    check("st_d_grant", d_grant, 1);
    d_wr = 1'b0;
    step();
    check("st_ack_pulse", d_wr_ack, 0);
    check("st_busy_after", busy, 0);
    check("st_wdata_zero", mem_wdata, 0);
    check("st_addr_zero", mem_addr, 0);

    // ---- stray mem_data_valid in IDLE ----
    clear_counts();
    stray = 1'b1;
    step();
    check("stray_valid_seen", mem_data_valid, 1);
    check("stray_i_dv", i_data_valid, 0);
    check("stray_d_dv", d_data_valid, 0);
    check("stray_busy", busy, 0);
    stray = 1'b0;
    d_addr = 16'h0500;
    d_miss = 1'b1;
    step();
    check("stray_d_grant", d_grant, 1);
    finish_fill(1'b0, tgt, idle);
    check("stray_done_lat", 32'(idle - tgt), 1);
    check("stray_d_vcnt", d_vcnt, 8);
    check("stray_beats", rd_beats, 8);
    step();

    // ---- asynchronous reset at beat 3 of D_FILL ----
    clear_counts();
    d_addr = 16'h0600;
    d_miss = 1'b1;
    budget = 0;
    while (rd_beats < 3 && budget < 20) begin
      step();
      budget++;
    end
    check("rb_reached_beat3", rd_beats, 3);
    rst = 1'b1;
    #1;
    check("rb_mem_enable", mem_enable, 0);
    check("rb_mem_addr", mem_addr, 0);
    check("rb_d_grant", d_grant, 0);
    check("rb_busy", busy, 0);
    check("rb_d_stall", d_stall, 0);
    d_miss = 1'b0;
    i_addr = 16'h0700;
    i_miss = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rb_i_grant_low", i_grant, 0);
    clear_counts();
    step();
    check("rb_i_grant", i_grant, 1);
    finish_fill(1'b1, tgt, idle);
    check("rb_done_lat", 32'(idle - tgt), 1);
    check("rb_i_vcnt", i_vcnt, 8);
    check("rb_d_vcnt", d_vcnt, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
